// File: rtl/selector_pkg.sv
// Shared definitions for the lowest-set-bit selector encoder:
// default widths, FSM state encoding and a log2 helper for the chunk width.
package selector_pkg;

    localparam int SEL_ADDR_W_DEFAULT  = 16;
    localparam int SEL_CHUNK_W_DEFAULT = 256;

    // Fixed 2-bit encoding so the state register keeps a stable layout.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sel_state_t;

    // Ceiling log2. Used for the local-index width of one chunk.
    function automatic int chunk_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/selector_chunk_penc.sv
// Combinational priority encoder for one CHUNK_W-bit slice: reports whether
// any bit is set, the index of the lowest set bit, and whether more than one
// bit is set.
module selector_chunk_penc
    import selector_pkg::*;
#(
    parameter int CHUNK_W = SEL_CHUNK_W_DEFAULT,
    parameter int LO_W    = chunk_log2(CHUNK_W)
) (
    input  logic [CHUNK_W-1:0] i_chunk,
    output logic               o_nonzero,
    output logic [LO_W-1:0]    o_lo_idx,
    output logic               o_more_than_one
);

    assign o_nonzero = |i_chunk;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign o_more_than_one = |(i_chunk & (i_chunk - CHUNK_W'(1)));

    // Walk from the top down so the last hit written is the lowest set bit.
    always_comb begin
        // NOTE: default assignment first, so no path leaves o_lo_idx unassigned (no latch).
        o_lo_idx = '0;
        for (int i = CHUNK_W - 1; i >= 0; i--) begin
            if (i_chunk[i]) begin
                o_lo_idx = LO_W'(i);
            end
        end
    end

endmodule

// File: rtl/selector_encoder_16.sv
// Multi-cycle lowest-set-bit encoder for a 2**ADDR_W-bit select vector.
// The vector is scanned one CHUNK_W-bit slice per clock from the bottom up.
// Optional build macro: MULTI_HOT_DETECT_EN adds the multi output and forces
// a full-length scan so multi-hot vectors are flagged.
// CHUNK_W must be a power of two smaller than 2**ADDR_W.
module selector_encoder_16
    import selector_pkg::*;
#(
    parameter int ADDR_W  = SEL_ADDR_W_DEFAULT,
    parameter int CHUNK_W = SEL_CHUNK_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [(2**ADDR_W)-1:0]   sel_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ADDR_W-1:0]        addr_out,
    output logic                     found,
`ifdef MULTI_HOT_DETECT_EN
    output logic                     multi,
`endif
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int WIDTH    = 2 ** ADDR_W;
    localparam int N_CHUNKS = WIDTH / CHUNK_W;
    localparam int LO_W     = chunk_log2(CHUNK_W);
    localparam int IDX_W    = ADDR_W - LO_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    sel_state_t        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_found;
`ifdef MULTI_HOT_DETECT_EN
    logic              r_multi;
`endif

    logic [ADDR_W-1:0]  w_base;
    logic [CHUNK_W-1:0] w_chunk;
    logic               w_nonzero;
    logic [LO_W-1:0]    w_lo_idx;
    logic               w_more_than_one;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_last;

    // Slice base and absolute address are concatenations, so no overflow is possible.
    assign w_base  = {r_idx, {LO_W{1'b0}}};
    assign w_chunk = sel_in[w_base +: CHUNK_W];
    assign w_addr  = {r_idx, w_lo_idx};
    assign w_last  = (r_idx == LAST_IDX);

    selector_chunk_penc #(
        .CHUNK_W (CHUNK_W),
        .LO_W    (LO_W)
    ) u_penc (
        .i_chunk         (w_chunk),
        .o_nonzero       (w_nonzero),
        .o_lo_idx        (w_lo_idx),
        .o_more_than_one (w_more_than_one)
    );

`ifndef MULTI_HOT_DETECT_EN
    // Slice multi-hot information has no consumer without the detection feature.
    logic w_unused_more_than_one;
    assign w_unused_more_than_one = w_more_than_one;
`endif

    // FSM, scan index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_addr  <= '0;
            r_found <= 1'b0;
`ifdef MULTI_HOT_DETECT_EN
            r_multi <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state <= ST_SCAN;
                        r_idx   <= '0;
                        r_addr  <= '0;
                        r_found <= 1'b0;
`ifdef MULTI_HOT_DETECT_EN
                        r_multi <= 1'b0;
`endif
                    end
                end
                ST_SCAN: begin
                    // Only the first nonzero slice contributes the address.
                    if (w_nonzero && !r_found) begin
                        r_addr  <= w_addr;
                        r_found <= 1'b1;
                    end
`ifdef MULTI_HOT_DETECT_EN
                    if (w_nonzero && (r_found || w_more_than_one)) begin
                        r_multi <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
`else
                    if (w_nonzero || w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign addr_out  = r_addr;
    assign found     = r_found;
`ifdef MULTI_HOT_DETECT_EN
    assign multi     = r_multi;
`endif

endmodule
